// File: rtl/bcd_count_source_pkg.sv
// ---------------------------------------------------------------------------
// bcd_count_source_pkg
// Shared definitions for the two-digit BCD count source.
//   state_t  : run/stop state of the counter
//   BCD_MAX  : largest legal value of one BCD digit
//   BCD_MIN  : smallest legal value of one BCD digit
// No ports; imported by bcd_count_source.
// ---------------------------------------------------------------------------
package bcd_count_source_pkg;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

endpackage

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
// Turns a raw, asynchronous pushbutton into a clean one-cycle press pulse:
// 2-flop synchronizer, then a debounce counter that only accepts a new level
// after the synchronized input has disagreed with the accepted level for
// DEB_CYCLES consecutive cycles, then a rising-edge pulse.
// Ports:
//   clk_in  : system clock
//   rst     : synchronous reset, active-high
//   i_btn   : raw button level (asynchronous)
//   o_press : one-cycle pulse when the accepted level goes 0 -> 1
// ---------------------------------------------------------------------------
module btn_conditioner #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_debCount;
    logic          r_press;

    // Two flops bring the raw button into the clock domain before anything
    // else looks at it.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // The debounce counter counts consecutive cycles in which the synchronized
    // level disagrees with the accepted one; any cycle of agreement restarts
    // it. On the cycle the new level is accepted, a press pulse is registered
    // if that new level is 1, so the pulse and the accepted level change on
    // the same edge.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_level    <= 1'b0;
            r_debCount <= '0;
            r_press    <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_debCount == DEB_LAST) begin
                    r_level    <= r_sync2;
                    r_debCount <= '0;
                    r_press    <= r_sync2;
                end else begin
                    r_debCount <= r_debCount + 1'b1;
                end
            end else begin
                r_debCount <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/bcd_count_source.sv
// ---------------------------------------------------------------------------
// bcd_count_source
// Two-digit BCD up/down counter (00..99) stepping at a prescaled tick rate.
// A go button toggles run/stop, a clear button zeroes the count, and a level
// switch picks the direction. WRAP selects roll-over or stop at the ends.
// Ports:
//   clk_in  : system clock
//   rst     : synchronous reset, active-high
//   btn_go  : raw pushbutton, each accepted press toggles run/stop
//   btn_clr : raw pushbutton, each accepted press clears the count to 00
//   up_dn   : raw level switch, 1 = count up, 0 = count down
//   SN0     : ones digit (BCD)
//   SN1     : tens digit (BCD)
//   running : 1 while the counter is in RUN
//   tc      : one-cycle pulse on the tick that hits the terminal count
// ---------------------------------------------------------------------------
module bcd_count_source
    import bcd_count_source_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int DEB_CYCLES = 500000,
    parameter int WRAP       = 1
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       btn_go,
    input  logic       btn_clr,
    input  logic       up_dn,
    output logic [3:0] SN0,
    output logic [3:0] SN1,
    output logic       running,
    output logic       tc
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic          w_goPress;
    logic          w_clrPress;
    logic          r_upSync1;
    logic          r_upSync2;
    state_t        r_state;
    state_t        w_nextState;
    logic [PW-1:0] r_prescale;
    logic [3:0]    r_ones;
    logic [3:0]    r_tens;
    logic          r_running;
    logic          r_tc;
    logic          w_tick;
    logic          w_atTerminal;
    logic          w_hit;

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_goCond (
        .clk_in (clk_in),
        .rst    (rst),
        .i_btn  (btn_go),
        .o_press(w_goPress)
    );

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_clrCond (
        .clk_in (clk_in),
        .rst    (rst),
        .i_btn  (btn_clr),
        .o_press(w_clrPress)
    );

    // The direction switch is a slow level, so it only needs synchronizing,
    // not debouncing; it is looked at only on a tick.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_upSync1 <= 1'b0;
            r_upSync2 <= 1'b0;
        end else begin
            r_upSync1 <= up_dn;
            r_upSync2 <= r_upSync1;
        end
    end

    // A terminal hit is a tick that lands on 99 going up or 00 going down.
    // A clear on the same cycle wins, so it suppresses both the count and
    // the hit. The go press toggles the state first and a non-wrapping hit
    // then forces STOP, so a coincident go and terminal stop ends in STOP.
    always_comb begin
        w_tick       = (r_state == ST_RUN) && (r_prescale == PRE_LAST);
        w_atTerminal = r_upSync2 ? ((r_tens == BCD_MAX) && (r_ones == BCD_MAX))
                                 : ((r_tens == BCD_MIN) && (r_ones == BCD_MIN));
        w_hit        = w_tick && !w_clrPress && w_atTerminal;
        w_nextState  = r_state;
        if (w_goPress) begin
            w_nextState = (r_state == ST_RUN) ? ST_STOP : ST_RUN;
        end
        if (w_hit && (WRAP == 0)) begin
            w_nextState = ST_STOP;
        end
    end

    // State, prescaler, digits and the registered outputs all move together.
    // The prescaler only advances on cycles where the counter is in RUN now
    // and stays in RUN, so it sits at 0 throughout STOP and the first tick
    // after starting arrives a full TICK_DIV cycles later.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state    <= ST_STOP;
            r_running  <= 1'b0;
            r_prescale <= '0;
            r_ones     <= BCD_MIN;
            r_tens     <= BCD_MIN;
            r_tc       <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_running <= (w_nextState == ST_RUN);
            r_tc      <= w_hit;

            if (w_clrPress || w_tick || (r_state != ST_RUN) || (w_nextState != ST_RUN)) begin
                r_prescale <= '0;
            end else begin
                r_prescale <= r_prescale + 1'b1;
            end

            if (w_clrPress) begin
                r_ones <= BCD_MIN;
                r_tens <= BCD_MIN;
            end else if (w_tick) begin
                if (w_atTerminal) begin
                    if (WRAP != 0) begin
                        r_ones <= r_upSync2 ? BCD_MIN : BCD_MAX;
                        r_tens <= r_upSync2 ? BCD_MIN : BCD_MAX;
                    end
                end else if (r_upSync2) begin
                    if (r_ones == BCD_MAX) begin
                        r_ones <= BCD_MIN;
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_ones <= r_ones + 4'd1;
                    end
                end else begin
                    if (r_ones == BCD_MIN) begin
                        r_ones <= BCD_MAX;
                        r_tens <= r_tens - 4'd1;
                    end else begin
                        r_ones <= r_ones - 4'd1;
                    end
                end
            end
        end
    end

    assign SN0     = r_ones;
    assign SN1     = r_tens;
    assign running = r_running;
    assign tc      = r_tc;

endmodule

// File: tb/tb_bcd_count_source.sv
// ---------------------------------------------------------------------------
// tb_bcd_count_source
// Drives a wrapping (index 0) and a holding (index 1) counter side by side
// and compares every cycle against a decimal reference model that treats
// the count as a plain integer 0..99 and the buttons as a sliding window of
// recent raw samples.
// ---------------------------------------------------------------------------
module tb_bcd_count_source;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int HL = DB + 2;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       goIn  [2];
    logic       clrIn [2];
    logic       udIn  [2];
    logic [3:0] sn0   [2];
    logic [3:0] sn1   [2];
    logic       runOut[2];
    logic       tcOut [2];

    int total = 0;
    int bad   = 0;

    int mVal      [2];
    bit mRun      [2];
    bit mTc       [2];
    int mRunCycles[2];
    bit mGoPulse  [2];
    bit mClrPulse [2];
    bit mGoAcc    [2];
    bit mClrAcc   [2];
    bit goHist [2][HL];
    bit clrHist[2][HL];
    bit udHist [2][HL];

    // 100 MHz-style free-running clock.
    always #5 clk_in = ~clk_in;

    bcd_count_source #(.TICK_DIV(TD), .DEB_CYCLES(DB), .WRAP(1)) dutWrap (
        .clk_in (clk_in),
        .rst    (rst),
        .btn_go (goIn[0]),
        .btn_clr(clrIn[0]),
        .up_dn  (udIn[0]),
        .SN0    (sn0[0]),
        .SN1    (sn1[0]),
        .running(runOut[0]),
        .tc     (tcOut[0])
    );

    bcd_count_source #(.TICK_DIV(TD), .DEB_CYCLES(DB), .WRAP(0)) dutHold (
        .clk_in (clk_in),
        .rst    (rst),
        .btn_go (goIn[1]),
        .btn_clr(clrIn[1]),
        .up_dn  (udIn[1]),
        .SN0    (sn0[1]),
        .SN1    (sn1[1]),
        .running(runOut[1]),
        .tc     (tcOut[1])
    );

    // Advances the reference model by one clock edge using the inputs that
    // were stable at that edge. Histories hold raw samples, newest at index 0;
    // the value the design sees through its synchronizer is two edges old.
    task automatic modelStep();
        bit tick;
        bit up;
        bit hit;
        bit wrap;
        bit runNext;
        bit flip;
        int newVal;
        for (int d = 0; d < 2; d++) begin
            for (int i = HL - 1; i > 0; i--) begin
                goHist[d][i]  = goHist[d][i-1];
                clrHist[d][i] = clrHist[d][i-1];
                udHist[d][i]  = udHist[d][i-1];
            end
            goHist[d][0]  = goIn[d];
            clrHist[d][0] = clrIn[d];
            udHist[d][0]  = udIn[d];
            if (rst) begin
                for (int i = 0; i < HL; i++) begin
                    goHist[d][i]  = 1'b0;
                    clrHist[d][i] = 1'b0;
                    udHist[d][i]  = 1'b0;
                end
                mVal[d] = 0; mRun[d] = 0; mTc[d] = 0; mRunCycles[d] = 0;
                mGoPulse[d] = 0; mClrPulse[d] = 0; mGoAcc[d] = 0; mClrAcc[d] = 0;
            end else begin
                wrap   = (d == 0);
                tick   = mRun[d] && ((mRunCycles[d] % TD) == TD - 1);
                up     = udHist[d][2];
                hit    = 1'b0;
                newVal = mVal[d];
                if (mClrPulse[d]) begin
                    newVal = 0;
                end else if (tick) begin
                    if (up) begin
                        if (mVal[d] == 99) begin
                            hit = 1'b1;
                            newVal = wrap ? 0 : 99;
                        end else begin
                            newVal = mVal[d] + 1;
                        end
                    end else begin
                        if (mVal[d] == 0) begin
                            hit = 1'b1;
                            newVal = wrap ? 99 : 0;
                        end else begin
                            newVal = mVal[d] - 1;
                        end
                    end
                end
                runNext = mRun[d] ^ mGoPulse[d];
                if (hit && !wrap) runNext = 1'b0;
                mRunCycles[d] = (mClrPulse[d] || !mRun[d] || !runNext) ? 0 : mRunCycles[d] + 1;
                mVal[d] = newVal;
                mTc[d]  = hit;
                mRun[d] = runNext;

                flip = 1'b1;
                for (int i = 2; i < HL; i++) if (goHist[d][i] == mGoAcc[d]) flip = 1'b0;
                mGoPulse[d] = 1'b0;
                if (flip) begin
                    mGoAcc[d]   = !mGoAcc[d];
                    mGoPulse[d] = mGoAcc[d];
                end
                flip = 1'b1;
                for (int i = 2; i < HL; i++) if (clrHist[d][i] == mClrAcc[d]) flip = 1'b0;
                mClrPulse[d] = 1'b0;
                if (flip) begin
                    mClrAcc[d]   = !mClrAcc[d];
                    mClrPulse[d] = mClrAcc[d];
                end
            end
        end
    endtask

    // Compares both counters against the model: digits, run flag, terminal
    // pulse, and that neither digit ever leaves 0..9.
    task automatic checkOutput();
        logic [7:0] expBcd;
        logic [7:0] gotBcd;
        logic       legal;
        for (int d = 0; d < 2; d++) begin
            expBcd = {4'(mVal[d] / 10), 4'(mVal[d] % 10)};
            gotBcd = {sn1[d], sn0[d]};
            total++;
            assert (gotBcd === expBcd) else begin
                bad++;
                $error("[TB] FAIL count[%0d] observed=%0h expected=%0h", d, gotBcd, expBcd);
            end
            total++;
            assert (runOut[d] === mRun[d]) else begin
                bad++;
                $error("[TB] FAIL running[%0d] observed=%0b expected=%0b", d, runOut[d], mRun[d]);
            end
            total++;
            assert (tcOut[d] === mTc[d]) else begin
                bad++;
                $error("[TB] FAIL tc[%0d] observed=%0b expected=%0b", d, tcOut[d], mTc[d]);
            end
            legal = (sn0[d] <= 4'd9) && (sn1[d] <= 4'd9);
            total++;
            assert (legal === 1'b1) else begin
                bad++;
                $error("[TB] FAIL bcdLegal[%0d] observed=%0h expected=digits<=9", d, gotBcd);
            end
        end
    endtask

    // Runs a number of clock cycles with the current inputs, checking after
    // every edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk_in);
            modelStep();
            #1;
            checkOutput();
        end
    endtask

    // Steps until the model's count for counter d reaches target, giving up
    // after a cycle budget and recording that as a failure.
    task automatic waitValue(input int d, input int target, input int budget);
        int n;
        n = 0;
        while ((mVal[d] != target) && (n < budget)) begin
            applyStimulus(1);
            n++;
        end
        total++;
        assert (mVal[d] == target) else begin
            bad++;
            $error("[TB] FAIL waitValue[%0d] observed=%0d expected=%0d", d, mVal[d], target);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            goIn[d] = 1'b0; clrIn[d] = 1'b0; udIn[d] = 1'b0;
        end

        $display("[TB] reset and idle");
        applyStimulus(2);
        rst = 1'b0;
        applyStimulus(50);

        $display("[TB] wrap counter: count up through 10 and on to 99");
        udIn[0] = 1'b1;
        goIn[0] = 1'b1;
        applyStimulus(6);
        goIn[0] = 1'b0;
        applyStimulus(45);
        waitValue(0, 99, 1000);
        applyStimulus(8);
        udIn[0] = 1'b0;
        applyStimulus(8);
        udIn[0] = 1'b1;
        applyStimulus(8);

        $display("[TB] clear at 47 coincident with a tick");
        waitValue(0, 46, 600);
        n = 0;
        while (!(mVal[0] == 46 && (mRunCycles[0] % TD) == TD - 1) && n < 8) begin
            applyStimulus(1);
            n++;
        end
        clrIn[0] = 1'b1;
        applyStimulus(6);
        clrIn[0] = 1'b0;
        applyStimulus(12);

        $display("[TB] go bounce rejection then a real press");
        goIn[0] = 1'b1; applyStimulus(1);
        goIn[0] = 1'b0; applyStimulus(6);
        goIn[0] = 1'b1; applyStimulus(2);
        goIn[0] = 1'b0; applyStimulus(8);
        goIn[0] = 1'b1; applyStimulus(4);
        goIn[0] = 1'b0; applyStimulus(10);

        $display("[TB] hold counter: count down to 00 and stop");
        udIn[1] = 1'b1;
        goIn[1] = 1'b1;
        applyStimulus(6);
        goIn[1] = 1'b0;
        waitValue(1, 2, 100);
        udIn[1] = 1'b0;
        applyStimulus(60);

        $display("[TB] randomized phase");
        repeat (300) begin
            for (int d = 0; d < 2; d++) begin
                goIn[d]  = ($urandom_range(0, 3) == 0);
                clrIn[d] = ($urandom_range(0, 7) == 0);
                udIn[d]  = $urandom_range(0, 1);
            end
            rst = ($urandom_range(0, 63) == 0);
            applyStimulus($urandom_range(1, 8));
            rst = 1'b0;
        end

        $display("[TB] reset in the middle of a count");
        for (int d = 0; d < 2; d++) begin
            goIn[d] = 1'b0; clrIn[d] = 1'b0;
        end
        udIn[0] = 1'b1;
        applyStimulus(10);
        if (!mRun[0]) begin
            goIn[0] = 1'b1;
            applyStimulus(6);
            goIn[0] = 1'b0;
        end
        applyStimulus(20);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        applyStimulus(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
